// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_pkg                                                     |
// | Purpose  : Core-wide constants, memory width encodings, store entry type |
// | Revision : 1.0 - initial store buffer support                            |
// +--------------------------------------------------------------------------+
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int DMEM_SIZE = 1024;
    localparam int DMEM_AW   = $clog2(DMEM_SIZE);

    localparam logic [2:0] MEM_B = 3'b000;
    localparam logic [2:0] MEM_H = 3'b001;
    localparam logic [2:0] MEM_W = 3'b010;

    typedef struct packed {
        logic               valid;
        logic [DMEM_AW-1:0] addr;
        logic [XLEN-1:0]    data;
        logic [2:0]         width;
    } sb_entry_t;

    function automatic logic [2:0] mem_size_bytes(input logic [2:0] width);
        case (width)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : store_buffer_fifo                                             |
// | Purpose  : Circular store-entry storage with head/tail pointers, count   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module store_buffer_fifo
    import riscv_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    localparam int PW      = $clog2(SB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  sb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    output sb_entry_t [SB_DEPTH-1:0]   entries_o,
    output logic      [PW-1:0]         head_o,
    output logic      [PW:0]           count_o
);

    sb_entry_t [SB_DEPTH-1:0] entries_q;
    logic      [PW-1:0]       head_q;
    logic      [PW-1:0]       tail_q;
    logic      [PW:0]         count_q;

    // Callers never push into a full buffer or pop an empty one.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (pop_i) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PW'(1);
            end
            if (push_i) begin
                entries_q[tail_q]       <= push_entry_i;
                entries_q[tail_q].valid <= 1'b1;
                tail_q                  <= tail_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign entries_o = entries_q;
    assign head_o    = head_q;
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : store_buffer                                                  |
// | Purpose  : In-order store buffer in front of data_memory; loads stall    |
// |            on byte overlap. Define SB_FWD_EN for exact-match forwarding. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module store_buffer
    import riscv_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int AW       = $clog2(DMEM_SIZE)
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            st_valid_i,
    output logic            st_ready_o,
    input  logic [AW-1:0]   st_addr_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [2:0]      st_width_i,
    input  logic            ld_valid_i,
    input  logic [AW-1:0]   ld_addr_i,
    input  logic [2:0]      ld_width_i,
    input  logic            ld_unsigned_i,
    output logic [XLEN-1:0] ld_data_o,
    output logic            ld_stall_o,
    input  logic            fence_i,
    output logic            empty_o,
    output logic [AW-1:0]   data_addr_o,
    output logic [XLEN-1:0] data_write_data_o,
    output logic            data_write_enable_o,
    output logic [2:0]      mem_width_o,
    output logic            mem_unsigned_o,
    input  logic [XLEN-1:0] data_read_data_i
);

    localparam int PW = $clog2(SB_DEPTH);

    sb_entry_t [SB_DEPTH-1:0] entries;
    sb_entry_t                push_entry;
    logic      [PW-1:0]       head;
    logic      [PW:0]         count;
    logic                     push;
    logic                     pop;
    logic      [AW:0]         ld_lo;
    logic      [AW:0]         ld_hi;
    logic      [SB_DEPTH-1:0] ovl;
    logic                     hazard;
    logic                     fwd_hit;
    logic      [XLEN-1:0]     fwd_data;
    logic                     unused_fence;

    // A fence needs no state: the core simply waits for empty_o.
    assign unused_fence = fence_i;

    assign st_ready_o = (count != (PW+1)'(SB_DEPTH));
    assign empty_o    = (count == '0);
    assign push       = st_valid_i && st_ready_o;
    assign push_entry = '{valid: 1'b1, addr: st_addr_i, data: st_data_i, width: st_width_i};

    store_buffer_fifo #(
        .SB_DEPTH     (SB_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .entries_o    (entries),
        .head_o       (head),
        .count_o      (count)
    );

    // Ranges carry an extra bit so an access at the top of memory cannot wrap.
    assign ld_lo = {1'b0, ld_addr_i};
    assign ld_hi = ld_lo + (AW+1)'(mem_size_bytes(ld_width_i)) - (AW+1)'(1);

    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_ovl
        logic [AW:0] e_lo;
        logic [AW:0] e_hi;
        assign e_lo   = {1'b0, entries[i].addr};
        assign e_hi   = e_lo + (AW+1)'(mem_size_bytes(entries[i].width)) - (AW+1)'(1);
        assign ovl[i] = entries[i].valid && ld_valid_i && (e_lo <= ld_hi) && (ld_lo <= e_hi);
    end

    assign hazard = |ovl;

`ifdef SB_FWD_EN
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] young_idx;
    logic [XLEN-1:0] raw;

    // Walk oldest to youngest so the last overlapping hit is the youngest one.
    always_comb begin
        scan_idx  = '0;
        young_idx = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (ovl[scan_idx]) begin
                young_idx = scan_idx;
            end
        end
        fwd_hit = hazard && (entries[young_idx].addr == ld_addr_i)
                         && (entries[young_idx].width == ld_width_i);
        raw     = entries[young_idx].data;
        case (ld_width_i)
            MEM_B:   fwd_data = ld_unsigned_i ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            MEM_H:   fwd_data = ld_unsigned_i ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: fwd_data = raw;
        endcase
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        data_addr_o         = '0;
        data_write_data_o   = '0;
        data_write_enable_o = 1'b0;
        mem_width_o         = '0;
        mem_unsigned_o      = 1'b0;
        ld_data_o           = '0;
        ld_stall_o          = 1'b0;
        pop                 = 1'b0;
        if (ld_valid_i && !hazard) begin
            data_addr_o    = ld_addr_i;
            mem_width_o    = ld_width_i;
            mem_unsigned_o = ld_unsigned_i;
            ld_data_o      = data_read_data_i;
        end else if (count != '0) begin
            data_addr_o         = entries[head].addr;
            data_write_data_o   = entries[head].data;
            data_write_enable_o = 1'b1;
            mem_width_o         = entries[head].width;
            pop                 = 1'b1;
            ld_stall_o          = ld_valid_i && !fwd_hit;
            if (ld_valid_i && fwd_hit) begin
                ld_data_o = fwd_data;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_ni) !(st_valid_i && ld_valid_i))
        else $warning("store_buffer: store and load presented in the same cycle");

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_store_buffer                                               |
// | Purpose  : Scoreboard bench for store_buffer with a byte memory model    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_store_buffer;
    import riscv_pkg::*;

    localparam int AW = $clog2(DMEM_SIZE);

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            st_valid_i, st_ready_o;
    logic [AW-1:0]   st_addr_i;
    logic [31:0]     st_data_i;
    logic [2:0]      st_width_i;
    logic            ld_valid_i;
    logic [AW-1:0]   ld_addr_i;
    logic [2:0]      ld_width_i;
    logic            ld_unsigned_i;
    logic [31:0]     ld_data_o;
    logic            ld_stall_o;
    logic            fence_i;
    logic            empty_o;
    logic [AW-1:0]   data_addr_o;
    logic [31:0]     data_write_data_o;
    logic            data_write_enable_o;
    logic [2:0]      mem_width_o;
    logic            mem_unsigned_o;
    logic [31:0]     data_read_data_i;

    always #5 clk = ~clk;

    store_buffer #(.SB_DEPTH(4)) dut (
        .clk                 (clk),
        .rst_ni              (rst_ni),
        .st_valid_i          (st_valid_i),
        .st_ready_o          (st_ready_o),
        .st_addr_i           (st_addr_i),
        .st_data_i           (st_data_i),
        .st_width_i          (st_width_i),
        .ld_valid_i          (ld_valid_i),
        .ld_addr_i           (ld_addr_i),
        .ld_width_i          (ld_width_i),
        .ld_unsigned_i       (ld_unsigned_i),
        .ld_data_o           (ld_data_o),
        .ld_stall_o          (ld_stall_o),
        .fence_i             (fence_i),
        .empty_o             (empty_o),
        .data_addr_o         (data_addr_o),
        .data_write_data_o   (data_write_data_o),
        .data_write_enable_o (data_write_enable_o),
        .mem_width_o         (mem_width_o),
        .mem_unsigned_o      (mem_unsigned_o),
        .data_read_data_i    (data_read_data_i)
    );

    // data_memory model: little-endian bytes, combinational read, write on edge
    logic [7:0]  mem [0:DMEM_SIZE-1];
    logic [31:0] rd_word;

    always_comb begin
        rd_word = {mem[data_addr_o + AW'(3)], mem[data_addr_o + AW'(2)],
                   mem[data_addr_o + AW'(1)], mem[data_addr_o]};
        case (mem_width_o)
            MEM_B:   data_read_data_i = mem_unsigned_o ? {24'h0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
            MEM_H:   data_read_data_i = mem_unsigned_o ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
            default: data_read_data_i = rd_word;
        endcase
    end

    always @(posedge clk) begin
        if (data_write_enable_o) begin
            mem[data_addr_o] <= data_write_data_o[7:0];
            if (mem_width_o != MEM_B) mem[data_addr_o + AW'(1)] <= data_write_data_o[15:8];
            if (mem_width_o == MEM_W) begin
                mem[data_addr_o + AW'(2)] <= data_write_data_o[23:16];
                mem[data_addr_o + AW'(3)] <= data_write_data_o[31:24];
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [2:0]    width;
    } wr_t;

    wr_t         exp_wr [$];
    logic [31:0] exp_ld [$];
    wr_t         e_wr;
    logic [31:0] e_ld;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every completed load is scored.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (data_write_enable_o) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got write to %h expected no write", data_addr_o);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(data_addr_o), 32'(e_wr.addr));
                    check("wr_data", data_write_data_o, e_wr.data);
                    check("wr_width", 32'(mem_width_o), 32'(e_wr.width));
                    check("wr_unsigned", 32'(mem_unsigned_o), 32'd0);
                end
            end
            if (ld_valid_i && !ld_stall_o) begin
                if (exp_ld.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load: got data %h expected no load", ld_data_o);
                end else begin
                    e_ld = exp_ld.pop_front();
                    check("ld_data", ld_data_o, e_ld);
                end
            end
        end
    end

    task automatic issue_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] w,
                               input bit with_ld, input int exp_wait);
        int waited = 0;
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_width_i = w;
        if (with_ld) begin
            ld_valid_i    = 1'b1;
            ld_addr_i     = AW'(10'h200);
            ld_width_i    = MEM_W;
            ld_unsigned_i = 1'b0;
            exp_ld.push_back(32'h03020100);
        end
        @(negedge clk);
        while (!st_ready_o && waited < 8) begin
            waited++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        exp_wr.push_back('{addr: a, data: d, width: w});
        check("st_wait", 32'(waited), 32'(exp_wait));
        @(posedge clk); #1;
        st_valid_i = 1'b0;
        ld_valid_i = 1'b0;
    endtask

    task automatic issue_load(input logic [AW-1:0] a, input logic [2:0] w, input logic uns,
                              input logic [31:0] exp_data, input int exp_stalls, input bit chk_nowr);
        int stalls = 0;
        ld_valid_i    = 1'b1;
        ld_addr_i     = a;
        ld_width_i    = w;
        ld_unsigned_i = uns;
        exp_ld.push_back(exp_data);
        @(negedge clk);
        while (ld_stall_o && stalls < 16) begin
            if (stalls == 0) check("stall_data_zero", ld_data_o, 32'd0);
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (chk_nowr) check("no_drain_on_load", 32'(data_write_enable_o), 32'd0);
        @(posedge clk); #1;
        ld_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (!empty_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", 32'(empty_o), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DMEM_SIZE; i++) mem[i] = i[7:0];
        rst_ni = 1'b0;  st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_width_i = '0;
        ld_valid_i = 1'b0; ld_addr_i = '0; ld_width_i = '0; ld_unsigned_i = 1'b0; fence_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_st_ready", 32'(st_ready_o), 32'd1);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_stall", 32'(ld_stall_o), 32'd0);
        check("rst_we", 32'(data_write_enable_o), 32'd0);
        check("rst_addr", 32'(data_addr_o), 32'd0);
        check("rst_wdata", data_write_data_o, 32'd0);
        check("rst_width_uns", {28'd0, mem_width_o, mem_unsigned_o}, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Fill: each store paired with a disjoint load holds the port off the drain.
        issue_store(AW'(10'h000), 32'h11, MEM_W, 1, 0);
        issue_store(AW'(10'h004), 32'h22, MEM_W, 1, 0);
        issue_store(AW'(10'h008), 32'h33, MEM_W, 1, 0);
        issue_store(AW'(10'h00C), 32'h44, MEM_W, 1, 0);
        check("full_ready_low", 32'(st_ready_o), 32'd0);
        check("full_not_empty", 32'(empty_o), 32'd0);
        wait_empty();
        issue_load(AW'(10'h008), MEM_W, 1'b0, 32'h00000033, 0, 1);

        // Byte store then dependent byte loads.
        issue_store(AW'(10'h010), 32'hAB, MEM_B, 0, 0);
`ifdef SB_FWD_EN
        issue_load(AW'(10'h010), MEM_B, 1'b0, 32'hFFFFFFAB, 0, 0);
`else
        issue_load(AW'(10'h010), MEM_B, 1'b0, 32'hFFFFFFAB, 1, 0);
`endif
        issue_load(AW'(10'h010), MEM_B, 1'b1, 32'h000000AB, 0, 1);

        // Partial overlap always stalls.
        issue_store(AW'(10'h020), 32'hDEADBEEF, MEM_W, 0, 0);
        issue_load(AW'(10'h022), MEM_H, 1'b0, 32'hFFFFDEAD, 1, 1);

        // Full buffer refuses a store even while draining.
        issue_store(AW'(10'h030), 32'h55, MEM_W, 1, 0);
        issue_store(AW'(10'h034), 32'h66, MEM_W, 1, 0);
        issue_store(AW'(10'h038), 32'h77, MEM_W, 1, 0);
        issue_store(AW'(10'h03C), 32'h88, MEM_W, 1, 0);
        check("full2_ready_low", 32'(st_ready_o), 32'd0);
        issue_store(AW'(10'h050), 32'h99, MEM_W, 0, 1);
        check("after_refuse_ready", 32'(st_ready_o), 32'd1);
        wait_empty();
        issue_load(AW'(10'h050), MEM_W, 1'b0, 32'h00000099, 0, 1);
        issue_load(AW'(10'h03C), MEM_W, 1'b0, 32'h00000088, 0, 1);

        // Disjoint load with pending stores is served at once, without a drain.
        issue_store(AW'(10'h060), 32'h101, MEM_W, 1, 0);
        issue_store(AW'(10'h064), 32'h202, MEM_W, 1, 0);
        issue_store(AW'(10'h068), 32'h303, MEM_W, 1, 0);
        issue_load(AW'(10'h040), MEM_W, 1'b0, 32'h43424140, 0, 1);
        wait_empty();
        issue_load(AW'(10'h064), MEM_W, 1'b0, 32'h00000202, 0, 1);

        // Reset with pending stores discards them.
        issue_store(AW'(10'h080), 32'hAAAA0001, MEM_W, 1, 0);
        issue_store(AW'(10'h084), 32'hAAAA0002, MEM_W, 1, 0);
        issue_store(AW'(10'h088), 32'hAAAA0003, MEM_W, 1, 0);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_empty", 32'(empty_o), 32'd1);
        check("rst_mid_we", 32'(data_write_enable_o), 32'd0);
        exp_wr.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue_load(AW'(10'h080), MEM_W, 1'b0, 32'h83828180, 0, 1);
        issue_load(AW'(10'h088), MEM_W, 1'b0, 32'h8B8A8988, 0, 1);

        repeat (2) @(posedge clk);
        check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        check("exp_ld_left", 32'(exp_ld.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
